capturador_numerico_teclado: RTL and testbench

- Sits directly downstream of the PS/2 keyboard controller. Consumes one ASCII character per key event, plus a one-cycle strobe for that event.
- Lets the user type a multi-digit decimal number, edit it and commit it. Supported keys: digits, Backspace, Escape and Enter.
- Delivers a range-checked binary value with a one-cycle valid pulse to the time/parameter-setting logic of the system.
- Also exposes the live BCD entry buffer so the display can echo digits as they are typed.

---
 rtl/capturador_numerico_teclado.sv | 179 +++++++++++++++++
 tb/tb_capturador_numerico_teclado.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/capturador_numerico_teclado.sv
// Numeric keypad entry: collects up to NUM_DIGITS decimal digits from ASCII key
// events, supports Backspace/Escape/Enter editing and commits a range-checked value.
module capturador_numerico_teclado #(
    parameter int NUM_DIGITS     = 2,
    parameter int MAX_VALUE      = 59,
    parameter int VALUE_W        = 7,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    key_strobe,
    input  logic [7:0]              ascii_in,
    output logic [4*NUM_DIGITS-1:0] digits_bcd,
    output logic [2:0]              digit_count,
    output logic                    entry_active,
    output logic [VALUE_W-1:0]      value_out,
    output logic                    value_valid,
    output logic                    entry_error,
    output logic                    key_reject,
    output logic                    entry_timeout
);

    localparam int BUF_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       COUNT_MAX = 3'(NUM_DIGITS);
    localparam logic [13:0]      VALUE_MAX = 14'(MAX_VALUE);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        K_NONE  = 3'd0,
        K_DIGIT = 3'd1,
        K_BKSP  = 3'd2,
        K_ESC   = 3'd3,
        K_ENTER = 3'd4
    } key_t;

    state_t           state;
    key_t             key;
    logic [CNT_W-1:0] timer;
    logic [13:0]      bin;

    // Horner evaluation of the BCD buffer, most significant digit first.
    function automatic logic [13:0] bcd_to_bin(input logic [BUF_W-1:0] b);
        logic [13:0] acc;
        acc = 14'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc = acc * 14'd10 + 14'(b[4*i +: 4]);
        end
        return acc;
    endfunction

    assign bin = bcd_to_bin(digits_bcd);

    // Key classification; unrecognised codes behave as if no strobe occurred.
    always_comb begin
        key = K_NONE;
        if (!key_strobe) begin
            key = K_NONE;
        end else if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
            key = K_DIGIT;
        end else if (ascii_in == 8'h08) begin
            key = K_BKSP;
        end else if (ascii_in == 8'h1B) begin
            key = K_ESC;
        end else if (ascii_in == 8'h0D) begin
            key = K_ENTER;
        end else begin
            key = K_NONE;
        end
    end

    // Entry state machine, buffer, timeout counter and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            entry_active  <= 1'b0;
            digits_bcd    <= {BUF_W{1'b0}};
            digit_count   <= 3'd0;
            timer         <= {CNT_W{1'b0}};
            value_out     <= {VALUE_W{1'b0}};
            value_valid   <= 1'b0;
            entry_error   <= 1'b0;
            key_reject    <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            value_valid   <= 1'b0;
            entry_error   <= 1'b0;
            key_reject    <= 1'b0;
            entry_timeout <= 1'b0;
            if (!enable) begin
                state        <= IDLE;
                entry_active <= 1'b0;
                digits_bcd   <= {BUF_W{1'b0}};
                digit_count  <= 3'd0;
                timer        <= {CNT_W{1'b0}};
            end else begin
                case (state)
                    IDLE: begin
                        timer <= {CNT_W{1'b0}};
                        if (key == K_DIGIT) begin
                            digits_bcd   <= BUF_W'(ascii_in[3:0]);
                            digit_count  <= 3'd1;
                            state        <= ENTRY;
                            entry_active <= 1'b1;
                        end
                    end
                    ENTRY: begin
                        case (key)
                            K_DIGIT: begin
                                timer <= {CNT_W{1'b0}};
                                if (digit_count < COUNT_MAX) begin
                                    digits_bcd  <= (digits_bcd << 4) | BUF_W'(ascii_in[3:0]);
                                    digit_count <= digit_count + 3'd1;
                                end else begin
                                    key_reject <= 1'b1;
                                end
                            end
                            K_BKSP: begin
                                timer       <= {CNT_W{1'b0}};
                                digits_bcd  <= digits_bcd >> 4;
                                digit_count <= digit_count - 3'd1;
                                if (digit_count == 3'd1) begin
                                    state        <= IDLE;
                                    entry_active <= 1'b0;
                                end
                            end
                            K_ESC: begin
                                digits_bcd   <= {BUF_W{1'b0}};
                                digit_count  <= 3'd0;
                                timer        <= {CNT_W{1'b0}};
                                state        <= IDLE;
                                entry_active <= 1'b0;
                            end
                            K_ENTER: begin
                                if (bin <= VALUE_MAX) begin
                                    value_out   <= bin[VALUE_W-1:0];
                                    value_valid <= 1'b1;
                                end else begin
                                    entry_error <= 1'b1;
                                end
                                digits_bcd   <= {BUF_W{1'b0}};
                                digit_count  <= 3'd0;
                                timer        <= {CNT_W{1'b0}};
                                state        <= IDLE;
                                entry_active <= 1'b0;
                            end
                            default: begin
                                if (timer == CNT_LAST) begin
                                    digits_bcd    <= {BUF_W{1'b0}};
                                    digit_count   <= 3'd0;
                                    timer         <= {CNT_W{1'b0}};
                                    state         <= IDLE;
                                    entry_active  <= 1'b0;
                                    entry_timeout <= 1'b1;
                                end else begin
                                    timer <= timer + CNT_W'(1);
                                end
                            end
                        endcase
                    end
                    default: begin
                        state        <= IDLE;
                        entry_active <= 1'b0;
                        digits_bcd   <= {BUF_W{1'b0}};
                        digit_count  <= 3'd0;
                        timer        <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capturador_numerico_teclado.sv
// Table-driven bench for capturador_numerico_teclado with a short timeout
// so the abandon path can be exercised in a few cycles.
module tb_capturador_numerico_teclado;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       key_strobe;
    logic [7:0] ascii_in;
    logic [7:0] digits_bcd;
    logic [2:0] digit_count;
    logic       entry_active;
    logic [6:0] value_out;
    logic       value_valid;
    logic       entry_error;
    logic       key_reject;
    logic       entry_timeout;

    always #5 clk = ~clk;

    capturador_numerico_teclado #(
        .NUM_DIGITS    (2),
        .MAX_VALUE     (59),
        .VALUE_W       (7),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .key_strobe   (key_strobe),
        .ascii_in     (ascii_in),
        .digits_bcd   (digits_bcd),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .value_out    (value_out),
        .value_valid  (value_valid),
        .entry_error  (entry_error),
        .key_reject   (key_reject),
        .entry_timeout(entry_timeout)
    );

    // pls = {value_valid, entry_error, key_reject, entry_timeout}
    typedef struct {
        string      tag;
        logic       rst;
        logic       en;
        logic       stb;
        logic [7:0] a;
        logic [7:0] bcd;
        logic [2:0] cnt;
        logic       act;
        logic [6:0] val;
        logic [3:0] pls;
    } vec_t;

    vec_t table_q[$];
    vec_t sb_q[$];
    int   applied     = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input string tag, input logic r, input logic e, input logic s,
                                input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                                input logic act, input logic [6:0] v, input logic [3:0] p);
        vec_t t;
        t.tag = tag; t.rst = r; t.en = e; t.stb = s; t.a = a;
        t.bcd = b; t.cnt = c; t.act = act; t.val = v; t.pls = p;
        return t;
    endfunction

    task automatic add(input string tag, input logic r, input logic e, input logic s,
                       input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                       input logic act, input logic [6:0] v, input logic [3:0] p);
        table_q.push_back(mk(tag, r, e, s, a, b, c, act, v, p));
    endtask

    task automatic apply(input vec_t t);
        vec_t       x;
        logic [3:0] got_p;
        @(negedge clk);
        reset      = t.rst;
        enable     = t.en;
        key_strobe = t.stb;
        ascii_in   = t.a;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
        x     = sb_q.pop_front();
        got_p = {value_valid, entry_error, key_reject, entry_timeout};
        applied++;
        if (digits_bcd !== x.bcd || digit_count !== x.cnt || entry_active !== x.act ||
            value_out !== x.val || got_p !== x.pls) begin
            miscompares++;
            $display("FAIL %s: got bcd=%h cnt=%0d act=%b val=%0d pls=%b, expected bcd=%h cnt=%0d act=%b val=%0d pls=%b",
                     x.tag, digits_bcd, digit_count, entry_active, value_out, got_p,
                     x.bcd, x.cnt, x.act, x.val, x.pls);
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        key_strobe = 1'b0;
        ascii_in   = 8'h00;

        add("reset",       1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd0,  4'b0000);
        add("t1_4",        1'b0, 1'b1, 1'b1, 8'h34, 8'h04, 3'd1, 1'b1, 7'd0,  4'b0000);
        add("t1_5",        1'b0, 1'b1, 1'b1, 8'h35, 8'h45, 3'd2, 1'b1, 7'd0,  4'b0000);
        add("t1_enter",    1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd45, 4'b1000);
        add("t1_after",    1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd45, 4'b0000);
        add("t2_7",        1'b0, 1'b1, 1'b1, 8'h37, 8'h07, 3'd1, 1'b1, 7'd45, 4'b0000);
        add("t2_2",        1'b0, 1'b1, 1'b1, 8'h32, 8'h72, 3'd2, 1'b1, 7'd45, 4'b0000);
        add("t2_err",      1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd45, 4'b0100);
        add("t2_after",    1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd45, 4'b0000);
        add("t3_1",        1'b0, 1'b1, 1'b1, 8'h31, 8'h01, 3'd1, 1'b1, 7'd45, 4'b0000);
        add("t3_2",        1'b0, 1'b1, 1'b1, 8'h32, 8'h12, 3'd2, 1'b1, 7'd45, 4'b0000);
        add("t3_reject",   1'b0, 1'b1, 1'b1, 8'h33, 8'h12, 3'd2, 1'b1, 7'd45, 4'b0010);
        add("t3_bksp1",    1'b0, 1'b1, 1'b1, 8'h08, 8'h01, 3'd1, 1'b1, 7'd45, 4'b0000);
        add("t3_bksp2",    1'b0, 1'b1, 1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 7'd45, 4'b0000);
        add("t3_idle_ent", 1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd45, 4'b0000);
        add("idle_esc",    1'b0, 1'b1, 1'b1, 8'h1B, 8'h00, 3'd0, 1'b0, 7'd45, 4'b0000);
        add("t4_3",        1'b0, 1'b1, 1'b1, 8'h33, 8'h03, 3'd1, 1'b1, 7'd45, 4'b0000);
        add("t4_enter",    1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd3,  4'b1000);
        add("t4_A_idle",   1'b0, 1'b1, 1'b1, 8'h41, 8'h00, 3'd0, 1'b0, 7'd3,  4'b0000);
        add("t4_9",        1'b0, 1'b1, 1'b1, 8'h39, 8'h09, 3'd1, 1'b1, 7'd3,  4'b0000);
        add("t4_A_entry",  1'b0, 1'b1, 1'b1, 8'h41, 8'h09, 3'd1, 1'b1, 7'd3,  4'b0000);
        add("esc_entry",   1'b0, 1'b1, 1'b1, 8'h1B, 8'h00, 3'd0, 1'b0, 7'd3,  4'b0000);
        add("lead0_0",     1'b0, 1'b1, 1'b1, 8'h30, 8'h00, 3'd1, 1'b1, 7'd3,  4'b0000);
        add("lead0_7",     1'b0, 1'b1, 1'b1, 8'h37, 8'h07, 3'd2, 1'b1, 7'd3,  4'b0000);
        add("lead0_ent",   1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd7,  4'b1000);
        add("max_5",       1'b0, 1'b1, 1'b1, 8'h35, 8'h05, 3'd1, 1'b1, 7'd7,  4'b0000);
        add("max_9",       1'b0, 1'b1, 1'b1, 8'h39, 8'h59, 3'd2, 1'b1, 7'd7,  4'b0000);
        add("max_ent",     1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd59, 4'b1000);
        add("over_6",      1'b0, 1'b1, 1'b1, 8'h36, 8'h06, 3'd1, 1'b1, 7'd59, 4'b0000);
        add("over_0",      1'b0, 1'b1, 1'b1, 8'h30, 8'h60, 3'd2, 1'b1, 7'd59, 4'b0000);
        add("over_ent",    1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd59, 4'b0100);
        add("t6_8",        1'b0, 1'b1, 1'b1, 8'h38, 8'h08, 3'd1, 1'b1, 7'd59, 4'b0000);
        add("t6_reset",    1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd0,  4'b0000);
        add("t6_5",        1'b0, 1'b1, 1'b1, 8'h35, 8'h05, 3'd1, 1'b1, 7'd0,  4'b0000);
        add("t6_ent",      1'b0, 1'b1, 1'b1, 8'h0D, 8'h00, 3'd0, 1'b0, 7'd5,  4'b1000);
        add("t6_8b",       1'b0, 1'b1, 1'b1, 8'h38, 8'h08, 3'd1, 1'b1, 7'd5,  4'b0000);
        add("t6_dis",      1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd5,  4'b0000);
        add("t6_dis_stb",  1'b0, 1'b0, 1'b1, 8'h32, 8'h00, 3'd0, 1'b0, 7'd5,  4'b0000);
        add("t6_reen",     1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd5,  4'b0000);
        add("rst_w_stb",   1'b1, 1'b1, 1'b1, 8'h34, 8'h00, 3'd0, 1'b0, 7'd0,  4'b0000);

        for (int i = 0; i < table_q.size(); i++) begin
            apply(table_q[i]);
        end

        // Timeout: strobe, 15 quiet cycles, then the terminal-count cycle.
        apply(mk("to_5", 1'b0, 1'b1, 1'b1, 8'h35, 8'h05, 3'd1, 1'b1, 7'd0, 4'b0000));
        for (int i = 0; i < 15; i++) begin
            apply(mk("to_wait", 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 3'd1, 1'b1, 7'd0, 4'b0000));
        end
        apply(mk("to_fire", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd0, 4'b0001));
        apply(mk("to_after", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd0, 4'b0000));

        // Strobe on the terminal-count cycle wins and restarts the count.
        apply(mk("tc_5", 1'b0, 1'b1, 1'b1, 8'h35, 8'h05, 3'd1, 1'b1, 7'd0, 4'b0000));
        for (int i = 0; i < 15; i++) begin
            apply(mk("tc_wait", 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 3'd1, 1'b1, 7'd0, 4'b0000));
        end
        apply(mk("tc_6", 1'b0, 1'b1, 1'b1, 8'h36, 8'h56, 3'd2, 1'b1, 7'd0, 4'b0000));
        for (int i = 0; i < 15; i++) begin
            apply(mk("tc_wait2", 1'b0, 1'b1, 1'b0, 8'h00, 8'h56, 3'd2, 1'b1, 7'd0, 4'b0000));
        end
        apply(mk("tc_fire", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 7'd0, 4'b0001));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
